// File: rtl/pop_pulse_sequencer_if.sv
// pop_pulse_sequencer_if: control/status bundle between the POP sequencer and its controller.
//   master: drives enable and the four phase lengths; observes the gates and cycle progress.
//   slave : the sequencer side.
//   sync_out exists only when POP_SYNC_OUT_EN is defined.
interface pop_pulse_sequencer_if #(parameter int CNT_W = 16, parameter int CYC_W = 16);
  logic             enable;
  logic [CNT_W-1:0] pump_len;
  logic [CNT_W-1:0] dark_len;
  logic [CNT_W-1:0] probe_len;
  logic [CNT_W-1:0] dead_len;
  logic             pump_out;
  logic             probe_out;
  logic             busy;
  logic             cycle_done;
  logic [CYC_W-1:0] cycle_count;
`ifdef POP_SYNC_OUT_EN
  logic             sync_out;
  modport master (output enable, pump_len, dark_len, probe_len, dead_len,
                  input pump_out, probe_out, busy, cycle_done, cycle_count, sync_out);
  modport slave  (input enable, pump_len, dark_len, probe_len, dead_len,
                  output pump_out, probe_out, busy, cycle_done, cycle_count, sync_out);
`else
  modport master (output enable, pump_len, dark_len, probe_len, dead_len,
                  input pump_out, probe_out, busy, cycle_done, cycle_count);
  modport slave  (input enable, pump_len, dark_len, probe_len, dead_len,
                  output pump_out, probe_out, busy, cycle_done, cycle_count);
`endif
endinterface

// File: rtl/pop_pulse_sequencer.sv
// pop_pulse_sequencer: repeating pump/dark/probe/dead POP cycle generator on clk_2M5.
//   clk_2M5 : 2.5 MHz tick clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of pop_pulse_sequencer_if (enable, lengths in; gates, busy,
//             cycle_done, cycle_count out; sync_out when POP_SYNC_OUT_EN is defined)
// Optional feature macro: POP_SYNC_OUT_EN (one-tick sync_out at the start of each PUMP).
module pop_pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 16
) (
  input logic clk_2M5,
  input logic rst_n,
  pop_pulse_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PUMP, DARK, PROBE, DEAD} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt, dark_l, probe_l, dead_l;
  logic last, load, fin;
  // Counter preload for a phase of length l; a zero length behaves as one tick.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction
  always_comb begin
    last = cnt == '0;
    // Latch point: leaving IDLE, or the last DEAD tick when cycling continues.
    load = bus.enable && (state == IDLE || (state == DEAD && last));
    nxt = state == IDLE ? (bus.enable ? PUMP : IDLE) :
          !last          ? state :
          state == PUMP  ? DARK :
          state == DARK  ? PROBE :
          state == PROBE ? DEAD :
          bus.enable     ? PUMP : IDLE;
    // The pump length goes straight into the counter, so it needs no latch register.
    nxt_cnt = load           ? ld(bus.pump_len) :
              state == IDLE  ? '0 :
              !last          ? cnt - 1'b1 :
              state == PUMP  ? ld(dark_l) :
              state == DARK  ? ld(probe_l) :
              state == PROBE ? ld(dead_l) : '0;
    // Outputs are registered from the next state, so the coming tick is the last DEAD tick.
    fin = nxt == DEAD && nxt_cnt == '0;
  end
  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dark_l <= '0;
      probe_l <= '0;
      dead_l <= '0;
      bus.pump_out <= 1'b0;
      bus.probe_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.cycle_done <= 1'b0;
      bus.cycle_count <= '0;
`ifdef POP_SYNC_OUT_EN
      bus.sync_out <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      dark_l <= load ? bus.dark_len : dark_l;
      probe_l <= load ? bus.probe_len : probe_l;
      dead_l <= load ? bus.dead_len : dead_l;
      bus.pump_out <= nxt == PUMP;
      bus.probe_out <= nxt == PROBE;
      bus.busy <= nxt != IDLE;
      bus.cycle_done <= fin;
      bus.cycle_count <= fin ? bus.cycle_count + 1'b1 : bus.cycle_count;
`ifdef POP_SYNC_OUT_EN
      bus.sync_out <= nxt == PUMP && state != PUMP;
`endif
    end
  end
endmodule

// File: tb/tb_pop_pulse_sequencer.sv
// tb_pop_pulse_sequencer: scoreboard bench for pop_pulse_sequencer (CYC_W=4 to reach the wrap).
module tb_pop_pulse_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int compared = 0;
  int mismatched = 0;
  int sync_seen = 0;
  logic [3:0] model_cnt = '0;
  typedef struct packed {
    logic pump, probe, busy, done, sync;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];

  pop_pulse_sequencer_if #(.CNT_W(16), .CYC_W(4)) bus();
  pop_pulse_sequencer #(.CNT_W(16), .CYC_W(4)) dut (.clk_2M5(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic p, input logic r, input logic d, input logic s);
    exp_t e;
    if (d) model_cnt = model_cnt + 4'd1;
    e = '{pump: p, probe: r, busy: 1'b1, done: d, sync: s, cnt: model_cnt};
    q.push_back(e);
  endtask

  task automatic push_cycle(input int p, input int d, input int r, input int t);
    int ep = p == 0 ? 1 : p;
    int ed = d == 0 ? 1 : d;
    int er = r == 0 ? 1 : r;
    int et = t == 0 ? 1 : t;
    for (int i = 0; i < ep; i++) push(1'b1, 1'b0, 1'b0, i == 0);
    for (int i = 0; i < ed; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < er; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < et; i++) push(1'b0, 1'b0, i == et - 1, 1'b0);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e = q.size() != 0 ? q.pop_front() : '{pump: 1'b0, probe: 1'b0, busy: 1'b0, done: 1'b0, sync: 1'b0, cnt: model_cnt};
      chk("pump_out", 8'(bus.pump_out), 8'(e.pump));
      chk("probe_out", 8'(bus.probe_out), 8'(e.probe));
      chk("busy", 8'(bus.busy), 8'(e.busy));
      chk("cycle_done", 8'(bus.cycle_done), 8'(e.done));
      chk("cycle_count", 8'(bus.cycle_count), 8'(e.cnt));
      chk("gate_overlap", 8'(bus.pump_out & bus.probe_out), 8'd0);
`ifdef POP_SYNC_OUT_EN
      chk("sync_out", 8'(bus.sync_out), 8'(e.sync));
      if (bus.sync_out === 1'b1) sync_seen++;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_len(input logic [15:0] p, input logic [15:0] d, input logic [15:0] r, input logic [15:0] t);
    bus.pump_len = p;
    bus.dark_len = d;
    bus.probe_len = r;
    bus.dead_len = t;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0;
    set_len(16'd0, 16'd0, 16'd0, 16'd0);
    #12;
    chk("rst_pump_out", 8'(bus.pump_out), 8'd0);
    chk("rst_probe_out", 8'(bus.probe_out), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_cycle_done", 8'(bus.cycle_done), 8'd0);
    chk("rst_cycle_count", 8'(bus.cycle_count), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    // Single cycle from a one-tick enable pulse.
    set_len(16'd3, 16'd5, 16'd2, 16'd4);
    bus.enable = 1'b1;
    push_cycle(3, 5, 2, 4);
    step(1);
    bus.enable = 1'b0;
    step(13);
    step(2);
    // Continuous run of 1-tick phases, 10 cycles.
    do_reset();
    set_len(16'd1, 16'd1, 16'd1, 16'd1);
    bus.enable = 1'b1;
    for (int c = 0; c < 10; c++) push_cycle(1, 1, 1, 1);
    step(39);
    bus.enable = 1'b0;
    step(1);
    chk("continuous_count", 8'(bus.cycle_count), 8'd10);
    step(2);
    // Zero lengths behave as one tick each.
    set_len(16'd0, 16'd0, 16'd0, 16'd0);
    bus.enable = 1'b1;
    for (int c = 0; c < 3; c++) push_cycle(0, 0, 0, 0);
    step(11);
    bus.enable = 1'b0;
    step(2);
    // Enable drops in DARK, pump_len changes in PROBE.
    set_len(16'd3, 16'd5, 16'd2, 16'd4);
    bus.enable = 1'b1;
    push_cycle(3, 5, 2, 4);
    step(5);
    bus.enable = 1'b0;
    step(4);
    bus.pump_len = 16'd7;
    step(5);
    step(2);
    bus.enable = 1'b1;
    push_cycle(7, 5, 2, 4);
    step(1);
    bus.enable = 1'b0;
    step(17);
    step(1);
    // Asynchronous reset in the middle of PROBE.
    set_len(16'd3, 16'd5, 16'd2, 16'd4);
    bus.enable = 1'b1;
    push_cycle(3, 5, 2, 4);
    step(1);
    bus.enable = 1'b0;
    step(8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_probe_out", 8'(bus.probe_out), 8'd0);
    chk("async_busy", 8'(bus.busy), 8'd0);
    chk("async_cycle_count", 8'(bus.cycle_count), 8'd0);
    q.delete();
    model_cnt = '0;
    #1;
    rst_n = 1'b1;
    bus.enable = 1'b1;
    push_cycle(3, 5, 2, 4);
    step(1);
    bus.enable = 1'b0;
    step(14);
    // 17 cycles to wrap the 4-bit cycle counter.
    do_reset();
    set_len(16'd1, 16'd1, 16'd1, 16'd1);
    bus.enable = 1'b1;
    sync_seen = 0;
    for (int c = 0; c < 17; c++) push_cycle(1, 1, 1, 1);
    step(67);
    bus.enable = 1'b0;
    step(2);
    chk("wrap_count", 8'(bus.cycle_count), 8'd1);
`ifdef POP_SYNC_OUT_EN
    chk("sync_pulses", 8'(sync_seen), 8'd17);
`endif
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
